// File: rtl/risc8_cdi.sv
// risc8_cdi: control/datapath interface stage of the 8-bit RISC core.
// Latches the decoded control word of each opcode byte, gathers the 0-3
// immediate bytes that follow it, then presents the whole instruction to
// the datapath as a one-cycle ex_valid pulse. Also holds the ALU flags.
module risc8_cdi (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [7:0]  fetch_byte,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  ctl_a1,
    input  logic [1:0]  ctl_a2,
    input  logic [1:0]  ctl_a3,
    input  logic [3:0]  ctl_alu_op,
    input  logic [1:0]  ctl_selb,
    input  logic        ctl_rw_en,
    input  logic [2:0]  ctl_selr,
    input  logic [1:0]  ctl_isize,
    input  logic [2:0]  alu_flags_in,
    input  logic        alu_flags_we,
    output logic        opcode_req,
    output logic        busy,
    output logic        ex_valid,
    output logic [7:0]  ex_instr,
    output logic [1:0]  ex_a1,
    output logic [1:0]  ex_a2,
    output logic [1:0]  ex_a3,
    output logic [3:0]  ex_alu_op,
    output logic [1:0]  ex_selb,
    output logic [2:0]  ex_selr,
    output logic [1:0]  ex_isize,
    output logic        ex_rw_en,
    output logic [23:0] ex_imm,
    output logic [2:0]  alu_comp
);

    typedef enum logic {
        S_OPCODE = 1'b0,
        S_IMM    = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] rem;
    logic [1:0] rem_nx;
    logic       accept;
    logic       fire;
    logic       ld_op;
    logic       ld_imm;
    logic       rw_en_q;
    logic [1:0] imm_idx;

    assign accept     = fetch_valid & ~stall & ~flush;
    assign opcode_req = (state == S_OPCODE);
    assign busy       = (state == S_IMM);
    // Immediate slot counts up from 0 while rem counts down from isize.
    assign imm_idx    = ex_isize - rem;
    // The latched write enable only reaches the datapath during the pulse.
    assign ex_rw_en   = rw_en_q & ex_valid;

    // State and remaining-byte counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OPCODE;
            rem   <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // Next-state logic and load strobes for the instruction latches.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        fire     = 1'b0;
        ld_op    = 1'b0;
        ld_imm   = 1'b0;
        if (flush) begin
            state_nx = S_OPCODE;
            rem_nx   = '0;
        end else if (accept) begin
            case (state)
                S_OPCODE: begin
                    ld_op  = 1'b1;
                    rem_nx = ctl_isize;
                    if (ctl_isize == 2'd0) begin
                        fire = 1'b1;
                    end else begin
                        state_nx = S_IMM;
                    end
                end
                S_IMM: begin
                    ld_imm = 1'b1;
                    rem_nx = rem - 2'd1;
                    if (rem <= 2'd1) begin
                        rem_nx   = '0;
                        fire     = 1'b1;
                        state_nx = S_OPCODE;
                    end
                end
                default: begin
                    state_nx = S_OPCODE;
                    rem_nx   = '0;
                end
            endcase
        end
    end

    // Instruction latches and the self-clearing execute pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_instr  <= '0;
            ex_a1     <= '0;
            ex_a2     <= '0;
            ex_a3     <= '0;
            ex_alu_op <= '0;
            ex_selb   <= '0;
            ex_selr   <= '0;
            ex_isize  <= '0;
            rw_en_q   <= 1'b0;
            ex_imm    <= '0;
        end else begin
            ex_valid <= fire;
            if (ld_op) begin
                ex_instr  <= fetch_byte;
                ex_a1     <= ctl_a1;
                ex_a2     <= ctl_a2;
                ex_a3     <= ctl_a3;
                ex_alu_op <= ctl_alu_op;
                ex_selb   <= ctl_selb;
                ex_selr   <= ctl_selr;
                ex_isize  <= ctl_isize;
                rw_en_q   <= ctl_rw_en;
                ex_imm    <= '0;
            end
            if (ld_imm) begin
                case (imm_idx)
                    2'd0:    ex_imm[7:0]   <= fetch_byte;
                    2'd1:    ex_imm[15:8]  <= fetch_byte;
                    2'd2:    ex_imm[23:16] <= fetch_byte;
                    default: ;
                endcase
            end
        end
    end

    // ALU comparison flags, updated regardless of fetch state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_comp <= '0;
        end else if (alu_flags_we) begin
            alu_comp <= alu_flags_in;
        end
    end

endmodule

// File: tb/tb_risc8_cdi.sv
// Self-checking bench for risc8_cdi. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Expected instructions are queued
// when their opcode is driven and compared when ex_valid pulses.
module tb_risc8_cdi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [7:0]  fetch_byte = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  ctl_a1 = '0;
    logic [1:0]  ctl_a2 = '0;
    logic [1:0]  ctl_a3 = '0;
    logic [3:0]  ctl_alu_op = '0;
    logic [1:0]  ctl_selb = '0;
    logic        ctl_rw_en = 1'b0;
    logic [2:0]  ctl_selr = '0;
    logic [1:0]  ctl_isize = '0;
    logic [2:0]  alu_flags_in = '0;
    logic        alu_flags_we = 1'b0;
    logic        opcode_req;
    logic        busy;
    logic        ex_valid;
    logic [7:0]  ex_instr;
    logic [1:0]  ex_a1;
    logic [1:0]  ex_a2;
    logic [1:0]  ex_a3;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_selb;
    logic [2:0]  ex_selr;
    logic [1:0]  ex_isize;
    logic        ex_rw_en;
    logic [23:0] ex_imm;
    logic [2:0]  alu_comp;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  instr;
        logic [1:0]  a1;
        logic [1:0]  a2;
        logic [1:0]  a3;
        logic [3:0]  alu;
        logic [1:0]  selb;
        logic [2:0]  selr;
        logic [1:0]  isz;
        logic        rw;
        logic [23:0] imm;
    } exp_t;

    exp_t sb[$];

    risc8_cdi dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .fetch_byte   (fetch_byte),
        .stall        (stall),
        .flush        (flush),
        .ctl_a1       (ctl_a1),
        .ctl_a2       (ctl_a2),
        .ctl_a3       (ctl_a3),
        .ctl_alu_op   (ctl_alu_op),
        .ctl_selb     (ctl_selb),
        .ctl_rw_en    (ctl_rw_en),
        .ctl_selr     (ctl_selr),
        .ctl_isize    (ctl_isize),
        .alu_flags_in (alu_flags_in),
        .alu_flags_we (alu_flags_we),
        .opcode_req   (opcode_req),
        .busy         (busy),
        .ex_valid     (ex_valid),
        .ex_instr     (ex_instr),
        .ex_a1        (ex_a1),
        .ex_a2        (ex_a2),
        .ex_a3        (ex_a3),
        .ex_alu_op    (ex_alu_op),
        .ex_selb      (ex_selb),
        .ex_selr      (ex_selr),
        .ex_isize     (ex_isize),
        .ex_rw_en     (ex_rw_en),
        .ex_imm       (ex_imm),
        .alu_comp     (alu_comp)
    );

    always #5 clk = ~clk;

    // Scoreboard: every execute pulse must match the oldest queued instruction.
    always @(negedge clk) begin
        exp_t e;
        exp_t obs;
        if (rst_n === 1'b1 && ex_valid === 1'b1) begin
            checks++;
            obs = '{ex_instr, ex_a1, ex_a2, ex_a3, ex_alu_op, ex_selb,
                    ex_selr, ex_isize, ex_rw_en, ex_imm};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: ex_valid with empty queue, got %h", obs);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL sb_instr: got %h expected %h", obs, e);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // Present an opcode byte with its decoded control word; queue expectation.
    task automatic drive_op(input logic [7:0] op, input logic [1:0] a1,
                            input logic [1:0] a2, input logic [1:0] a3,
                            input logic [3:0] alu, input logic [1:0] selb,
                            input logic rw, input logic [2:0] selr,
                            input logic [1:0] isz, input logic [23:0] imm,
                            input bit push);
        fetch_valid = 1'b1;
        fetch_byte  = op;
        ctl_a1      = a1;
        ctl_a2      = a2;
        ctl_a3      = a3;
        ctl_alu_op  = alu;
        ctl_selb    = selb;
        ctl_rw_en   = rw;
        ctl_selr    = selr;
        ctl_isize   = isz;
        if (push) sb.push_back('{op, a1, a2, a3, alu, selb, selr, isz, rw, imm});
    endtask

    // Present an immediate byte; decoder outputs are garbage and must be ignored.
    task automatic drive_byte(input logic [7:0] b);
        logic [31:0] junk;
        junk        = $urandom;
        fetch_valid = 1'b1;
        fetch_byte  = b;
        ctl_a1      = junk[1:0];
        ctl_a2      = junk[3:2];
        ctl_a3      = junk[5:4];
        ctl_alu_op  = junk[9:6];
        ctl_selb    = junk[11:10];
        ctl_rw_en   = junk[12];
        ctl_selr    = junk[15:13];
        ctl_isize   = junk[17:16];
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        fetch_byte  = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({ex_valid, ex_instr, ex_a1, ex_a2, ex_a3, ex_alu_op, ex_selb,
             ex_selr, ex_isize, ex_rw_en, ex_imm} !== '0) begin
            errors++;
            $display("FAIL reset_ex: ex_* not all zero, instr=%h imm=%h valid=%b",
                     ex_instr, ex_imm, ex_valid);
        end
        checks++;
        if (opcode_req !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: opcode_req=%b busy=%b expected 1 0", opcode_req, busy);
        end
        checks++;
        if (alu_comp !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: alu_comp=%b expected 000", alu_comp);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drive_op(8'h44, 2'd1, 2'd2, 2'd3, 4'd1, 2'd1, 1'b1, 3'd2, 2'd0, 24'h0, 1'b1);
        @(negedge clk);
        idle();
        checks++;
        if (ex_valid !== 1'b1 || ex_rw_en !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse: ex_valid=%b ex_rw_en=%b expected 1 1", ex_valid, ex_rw_en);
        end
        @(negedge clk);
        checks++;
        if (ex_valid !== 1'b0 || ex_rw_en !== 1'b0) begin
            errors++;
            $display("FAIL single_clear: ex_valid=%b ex_rw_en=%b expected 0 0", ex_valid, ex_rw_en);
        end
    endtask

    task automatic test_imm2();
        drive_op(8'h80, 2'd3, 2'd0, 2'd1, 4'd2, 2'd2, 1'b1, 3'd5, 2'd2, 24'h001234, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || opcode_req !== 1'b0) begin
            errors++;
            $display("FAIL imm2_busy0: busy=%b opcode_req=%b expected 1 0", busy, opcode_req);
        end
        drive_byte(8'h34);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL imm2_busy1: busy=%b ex_valid=%b expected 1 0", busy, ex_valid);
        end
        drive_byte(8'h12);
        @(negedge clk);
        idle();
        checks++;
        if (ex_valid !== 1'b1 || opcode_req !== 1'b1) begin
            errors++;
            $display("FAIL imm2_done: ex_valid=%b opcode_req=%b expected 1 1", ex_valid, opcode_req);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int pulses;
        pulses = 0;
        drive_op(8'hC3, 2'd2, 2'd2, 2'd0, 4'd7, 2'd3, 1'b0, 3'd1, 2'd3, 24'hCCBBAA, 1'b1);
        @(negedge clk);
        drive_byte(8'hAA);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            drive_byte(8'h5A);
            @(negedge clk);
            if (ex_valid === 1'b1) pulses++;
            checks++;
            if (busy !== 1'b1 || ex_imm[15:8] !== 8'h00) begin
                errors++;
                $display("FAIL stall_hold: busy=%b imm=%h expected 1 with byte1 00", busy, ex_imm);
            end
        end
        stall = 1'b0;
        drive_byte(8'hBB);
        @(negedge clk);
        if (ex_valid === 1'b1) pulses++;
        drive_byte(8'hCC);
        @(negedge clk);
        idle();
        if (ex_valid === 1'b1) pulses++;
        @(negedge clk);
        if (ex_valid === 1'b1) pulses++;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL stall_pulses: got %0d ex_valid pulses expected 1", pulses);
        end
    endtask

    task automatic test_flags();
        drive_op(8'h0F, 2'd0, 2'd1, 2'd2, 4'd3, 2'd2, 1'b1, 3'd3, 2'd1, 24'h000077, 1'b1);
        @(negedge clk);
        stall        = 1'b1;
        drive_byte(8'h99);
        alu_flags_in = 3'b101;
        alu_flags_we = 1'b1;
        @(negedge clk);
        checks++;
        if (alu_comp !== 3'b101 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flags_we: alu_comp=%b busy=%b expected 101 1", alu_comp, busy);
        end
        alu_flags_in = 3'b010;
        alu_flags_we = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_comp !== 3'b101) begin
            errors++;
            $display("FAIL flags_hold: alu_comp=%b expected 101", alu_comp);
        end
        stall = 1'b0;
        drive_byte(8'h77);
        @(negedge clk);
        idle();
        checks++;
        if (ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL flags_instr: ex_valid=%b expected 1", ex_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        drive_op(8'hF0, 2'd1, 2'd1, 2'd1, 4'd5, 2'd1, 1'b1, 3'd4, 2'd3, 24'h0, 1'b0);
        @(negedge clk);
        drive_byte(8'hAA);
        @(negedge clk);
        flush = 1'b1;
        drive_byte(8'hEE);
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (opcode_req !== 1'b1 || ex_valid !== 1'b0 || ex_rw_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: opcode_req=%b ex_valid=%b ex_rw_en=%b expected 1 0 0",
                     opcode_req, ex_valid, ex_rw_en);
        end
        checks++;
        if (ex_instr !== 8'hF0 || ex_imm !== 24'h0000AA) begin
            errors++;
            $display("FAIL flush_retain: instr=%h imm=%h expected f0 0000aa", ex_instr, ex_imm);
        end
        drive_op(8'hEE, 2'd2, 2'd3, 2'd0, 4'd9, 2'd0, 1'b1, 3'd6, 2'd0, 24'h0, 1'b1);
        @(negedge clk);
        idle();
        checks++;
        if (ex_valid !== 1'b1 || ex_instr !== 8'hEE) begin
            errors++;
            $display("FAIL flush_next: ex_valid=%b instr=%h expected 1 ee", ex_valid, ex_instr);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [3];
        ops[0] = 8'h11;
        ops[1] = 8'h22;
        ops[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], 2'(i), 2'(i + 1), 2'(i + 2), 4'(i + 4), 2'(i),
                     i[0], 3'(i + 1), 2'd0, 24'h0, 1'b1);
            @(negedge clk);
            checks++;
            if (ex_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_valid%0d: ex_valid=%b expected 1", i, ex_valid);
            end
        end
        idle();
        @(negedge clk);
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: ex_valid=%b expected 0", ex_valid);
        end
    endtask

    task automatic test_async_reset();
        drive_op(8'h99, 2'd3, 2'd3, 2'd3, 4'd15, 2'd3, 1'b1, 3'd7, 2'd2, 24'h0, 1'b0);
        @(negedge clk);
        drive_byte(8'h55);
        @(negedge clk);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_instr, ex_a1, ex_a2, ex_a3, ex_alu_op, ex_selb,
             ex_selr, ex_isize, ex_rw_en, ex_imm, alu_comp} !== '0) begin
            errors++;
            $display("FAIL async_rst_out: instr=%h imm=%h alu_comp=%b expected all zero",
                     ex_instr, ex_imm, alu_comp);
        end
        checks++;
        if (opcode_req !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_state: opcode_req=%b busy=%b expected 1 0", opcode_req, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_op(8'h5C, 2'd1, 2'd0, 2'd2, 4'd6, 2'd2, 1'b0, 3'd2, 2'd1, 24'h0000E7, 1'b1);
        @(negedge clk);
        drive_byte(8'hE7);
        @(negedge clk);
        idle();
        checks++;
        if (ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_recover: ex_valid=%b expected 1", ex_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_imm2();
        test_stall();
        test_flags();
        test_flush();
        test_back_to_back();
        test_async_reset();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d instructions never executed expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
